// File: rtl/prio_grant_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// prio_grant_ctrl_pkg
//   Shared definitions for the 4-requester grant controller.
//   - state_t   : controller state encoding (IDLE / GRANT / RELEASE)
//   - N_REQ     : number of requesters
//   - CNT_W     : width of the grant-duration counter
//   - ID_W      : width of a requester index
//   - id_to_onehot() : turns a requester index into its one-hot grant vector
// -----------------------------------------------------------------------------
package prio_grant_ctrl_pkg;

  localparam int N_REQ = 4;
  localparam int CNT_W = 4;
  localparam int ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return N_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/prio_grant_ctrl_pick.sv
// -----------------------------------------------------------------------------
// rr_prio_pick
//   Purely combinational winner selection. The request vector is rotated so
//   that requester 'ptr' sits at bit 0, a casez priority decode picks the
//   lowest set bit of the rotated vector, and the result is rotated back.
//   With ptr tied to 0 this is plain fixed priority (req[0] highest).
//
//   Ports:
//     req       in  [N_REQ-1:0] request lines, bit i = requester i
//     ptr       in  [ID_W-1:0]  requester that gets top priority
//     winner    out [N_REQ-1:0] one-hot winner, all zero when req == 0
//     winner_id out [ID_W-1:0]  binary index of the winner (0 when req == 0)
// -----------------------------------------------------------------------------
module rr_prio_pick
  import prio_grant_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] winner,
  output logic [ID_W-1:0]  winner_id
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [ID_W-1:0]    rot_id;
  logic               rot_vld;
  logic [N_REQ-1:0]   rot_win;
  logic [2*N_REQ-1:0] win_dbl;

  // Rotate right by ptr, decode, then rotate the one-hot result back left.
  // Doubling the vector turns both rotations into plain part-selects/shifts.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: N_REQ];

    rot_id  = '0;
    rot_vld = 1'b1;
    casez (req_rot)
      4'b???1: rot_id = 2'd0;
      4'b??10: rot_id = 2'd1;
      4'b?100: rot_id = 2'd2;
      4'b1000: rot_id = 2'd3;
      default: rot_vld = 1'b0;
    endcase

    rot_win = rot_vld ? id_to_onehot(rot_id) : '0;
    win_dbl = {rot_win, rot_win} << ptr;
    winner  = win_dbl[2*N_REQ-1:N_REQ];

    // Index in the rotated frame plus the offset wraps naturally in ID_W bits.
    winner_id = rot_vld ? ID_W'(rot_id + ptr) : '0;
  end

endmodule

// File: rtl/prio_grant_ctrl.sv
// -----------------------------------------------------------------------------
// prio_grant_ctrl
//   Grants a shared resource to one of four requesters at a time. A grant is
//   held until the resource strobes 'done' or until TIMEOUT grant cycles have
//   elapsed, then one RELEASE cycle and one IDLE cycle separate it from the
//   next grant. Arbitration is either fixed priority (RR=0, req[0] highest)
//   or round-robin (RR=1, search starts just after the last winner).
//
//   Parameters:
//     RR       0 = fixed priority, 1 = round-robin
//     TIMEOUT  maximum grant length in cycles, legal range 2..15
//
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous active-high reset
//     req      in   [3:0] request lines
//     done     in   completion strobe, only looked at while granted
//     gnt      out  [3:0] registered one-hot grant
//     gnt_id   out  [1:0] registered index of the current/last winner
//     busy     out  registered, high while a grant is held
//     timeout  out  registered one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module prio_grant_ctrl
  import prio_grant_ctrl_pkg::*;
#(
  parameter int RR      = 1,
  parameter int TIMEOUT = 15
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  // Last counter value that is still a legal grant cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic [ID_W-1:0]    pick_id;
  logic               grant_expire;

  rr_prio_pick u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .winner    (pick_gnt),
    .winner_id (pick_id)
  );

  // A forced release only happens when done is low; a simultaneous done
  // takes priority and turns the release into a normal one.
  assign grant_expire = (state_q == GRANT) && !done && (cnt_q == CNT_LAST);

  // State register plus every registered output and bookkeeping flop.
  // Reset wins over everything, so a grant in progress is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic. RELEASE always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req != '0) state_d = GRANT;
      GRANT:   if (done || grant_expire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. Outputs are computed one cycle ahead so that
  // the registered values line up with the state they describe.
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (state_d == GRANT) begin
          gnt_d    = pick_gnt;
          gnt_id_d = pick_id;
          busy_d   = 1'b1;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end

      GRANT: begin
        // The winner is frozen here; req is not looked at until IDLE.
        if (!done) cnt_d = cnt_q + 1'b1;
        if (state_d == RELEASE) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = grant_expire;
          if (RR != 0) ptr_d = gnt_id_q + 1'b1;
        end
      end

      RELEASE: begin
        // gnt_id keeps the last winner for observers after the grant ends.
        gnt_d  = '0;
        busy_d = 1'b0;
      end

      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/prio_grant_ctrl.md
PRIO_GRANT_CTRL -- requirements
Module: prio_grant_ctrl

Interface
REQ-001 Parameter RR, default 1, selects arbitration: 0 = fixed priority, 1 = round-robin.
REQ-002 Parameter TIMEOUT, default 15, is the maximum number of GRANT cycles; legal range is 2..15.
REQ-003 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, is the reset: synchronous, active-high.
REQ-005 Port req, input, 4 bits, carries one request line per requester; bit i is requester i.
REQ-006 Port done, input, 1 bit, is the completion strobe from the shared resource.
REQ-007 Port gnt, output, 4 bits, is the one-hot grant, registered.
REQ-008 Port gnt_id, output, 2 bits, is the binary index of the granted requester, registered.
REQ-009 Port busy, output, 1 bit, is high while a grant is held, registered.
REQ-010 Port timeout, output, 1 bit, is a one-cycle flag for a forced release, registered.

Function
REQ-011 The FSM SHALL have states IDLE, GRANT and RELEASE.
REQ-012 Transitions SHALL be:
- IDLE -> GRANT when req != 0; otherwise stay in IDLE.
- GRANT -> RELEASE on done, or on timeout.
- RELEASE -> IDLE, unconditionally.
REQ-013 Fixed-priority mode SHALL use wildcard priority decode with req[0] highest and req[3] lowest.
REQ-014 Round-robin mode SHALL search from pointer ptr upward and wrap 3 -> 0; the first set bit wins.
REQ-015 Latency: req sampled in IDLE at edge k SHALL give gnt/gnt_id/busy valid after edge k, i.e. during the GRANT cycle.
REQ-016 In GRANT, gnt and gnt_id SHALL stay stable and ignore req changes; there is no preemption, even if the winner drops req.
REQ-017 A 4-bit counter cnt SHALL be cleared on GRANT entry and increment on each GRANT cycle where done=0.
REQ-018 If done=0 and cnt == TIMEOUT-1 in GRANT, the FSM SHALL go to RELEASE and assert timeout for the RELEASE cycle only.
REQ-019 If done=1 on the same cycle as the timeout condition, done SHALL win and timeout SHALL stay 0.
REQ-020 In RELEASE, gnt SHALL be 0 and busy SHALL be 0; gnt_id SHALL hold its last value.
REQ-021 In RR mode, ptr SHALL update to (gnt_id+1) mod 4 on RELEASE entry; in fixed mode, ptr stays 0.
REQ-022 The minimum gap between consecutive grants SHALL be 2 cycles with gnt=0 (RELEASE, then IDLE).
REQ-023 done SHALL be ignored in IDLE and RELEASE.
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 When rst=1 at a clock edge, the following SHALL take their reset values regardless of state:
- state = IDLE, ptr = 0, cnt = 0;
- gnt = 0, gnt_id = 0, busy = 0, timeout = 0.
REQ-026 Reset during GRANT SHALL drop gnt at that edge, with no RELEASE cycle and no timeout pulse.

Structure
REQ-027 A shared package SHALL hold:
- the state encoding: IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10;
- N_REQ=4 and CNT_W=4.
REQ-028 A combinational sub-module rr_prio_pick SHALL implement the selection:
- inputs: req and ptr; outputs: one-hot winner and 2-bit index;
- function: rotate req by ptr, apply casez priority decode, un-rotate the result.

Verification
REQ-029 Fixed-priority selection: RR=0, req=4'b1010 in IDLE -> next cycle gnt=4'b0010, gnt_id=1, busy=1; done pulse -> RELEASE with gnt=0.
REQ-030 Round-robin rotation: RR=1, req held at 4'b1111 with done one cycle after each grant -> gnt_id sequence 0,1,2,3,0 with 2 idle cycles between grants.
REQ-031 Forced release: TIMEOUT=4, done never asserted -> gnt held exactly 4 cycles, then timeout=1 for 1 cycle and busy=0.
REQ-032 Done/timeout collision: TIMEOUT=4, done=1 on the 4th GRANT cycle -> RELEASE entered with timeout=0.
REQ-033 Reset and no preemption: rst=1 on the 2nd GRANT cycle -> all outputs 0 next cycle and ptr=0. Separately, winner drops req mid-grant -> gnt unchanged until done.
REQ-034 Every scenario SHALL check that gnt is one-hot or zero on every cycle.
